// File: rtl/npc_bht_predictor.sv
// npc_bht_predictor: fetch PC register with 2-bit BHT branch prediction, delay slot, E-stage mispredict redirect (optional NPC_PRED_STATS_EN counters)
module npc_bht_predictor #(
  parameter logic [31:0] RESET_PC = 32'h0000_3000,
  parameter int BHT_IDX_W = 6,
  parameter logic [1:0] CNT_INIT = 2'b01
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic [2:0]  D_NPC_sel,
  input  logic [31:0] PC_D,
  input  logic [15:0] I16,
  input  logic [25:0] I26,
  input  logic [31:0] D_rs_val,
  input  logic        E_br_valid,
  input  logic [31:0] E_PC,
  input  logic [15:0] E_I16,
  input  logic        E_pred_taken,
  input  logic        E_b_jump,
  output logic [31:0] PC_F,
  output logic        D_pred_taken,
  output logic        mispredict,
  output logic        flush_F
`ifdef NPC_PRED_STATS_EN
  ,
  output logic [31:0] br_cnt,
  output logic [31:0] mispred_cnt
`endif
);
  logic [1:0] bht [2**BHT_IDX_W];
  logic [BHT_IDX_W-1:0] d_idx, e_idx;
  logic [1:0] e_cnt, e_cnt_nxt;
  logic [31:0] br_tgt_d, j_tgt, e_taken_tgt, e_fall, npc;
  assign d_idx = PC_D[BHT_IDX_W+1:2];
  assign e_idx = E_PC[BHT_IDX_W+1:2];
  assign br_tgt_d = PC_D + 32'd4 + {{14{I16[15]}}, I16, 2'b00};
  assign j_tgt = {PC_D[31:28], I26, 2'b00};
  assign e_taken_tgt = E_PC + 32'd4 + {{14{E_I16[15]}}, E_I16, 2'b00};
  assign e_fall = E_PC + 32'd8;
  assign D_pred_taken = (D_NPC_sel == 3'd2) & bht[d_idx][1];
  assign mispredict = E_br_valid & (E_pred_taken != E_b_jump);
  assign flush_F = mispredict;
  assign e_cnt = bht[e_idx];
  always_comb begin
    e_cnt_nxt = E_b_jump ? ((e_cnt == 2'd3) ? 2'd3 : e_cnt + 2'd1)
                         : ((e_cnt == 2'd0) ? 2'd0 : e_cnt - 2'd1);
    npc = mispredict ? (E_b_jump ? e_taken_tgt : e_fall) :
          stall ? PC_F :
          (D_NPC_sel == 3'd1) ? j_tgt :
          (D_NPC_sel == 3'd3) ? D_rs_val :
          D_pred_taken ? br_tgt_d : PC_F + 32'd4;
  end
  always_ff @(posedge clk) PC_F <= reset ? RESET_PC : npc;
  always_ff @(posedge clk) begin
    if (reset) for (int i = 0; i < 2**BHT_IDX_W; i++) bht[i] <= CNT_INIT;
    else if (E_br_valid) bht[e_idx] <= e_cnt_nxt;
  end
`ifdef NPC_PRED_STATS_EN
  always_ff @(posedge clk) begin
    br_cnt <= reset ? 32'd0 : br_cnt + {31'd0, E_br_valid};
    mispred_cnt <= reset ? 32'd0 : mispred_cnt + {31'd0, mispredict};
  end
`endif
endmodule

// File: tb/tb_npc_bht_predictor.sv
// tb_npc_bht_predictor: directed self-checking bench for npc_bht_predictor
module tb_npc_bht_predictor;
  logic clk = 0, reset, stall, E_br_valid, E_pred_taken, E_b_jump;
  logic [2:0] D_NPC_sel;
  logic [31:0] PC_D, D_rs_val, E_PC, PC_F;
  logic [15:0] I16, E_I16;
  logic [25:0] I26;
  logic D_pred_taken, mispredict, flush_F;
  int checks = 0, errors = 0;
`ifdef NPC_PRED_STATS_EN
  logic [31:0] br_cnt, mispred_cnt;
`endif
  npc_bht_predictor dut (
    .clk(clk), .reset(reset), .stall(stall), .D_NPC_sel(D_NPC_sel), .PC_D(PC_D),
    .I16(I16), .I26(I26), .D_rs_val(D_rs_val), .E_br_valid(E_br_valid), .E_PC(E_PC),
    .E_I16(E_I16), .E_pred_taken(E_pred_taken), .E_b_jump(E_b_jump), .PC_F(PC_F),
    .D_pred_taken(D_pred_taken), .mispredict(mispredict), .flush_F(flush_F)
`ifdef NPC_PRED_STATS_EN
    , .br_cnt(br_cnt), .mispred_cnt(mispred_cnt)
`endif
  );
  always #5 clk = ~clk;
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  task automatic idle_inputs;
    stall = 0; D_NPC_sel = 0; PC_D = 0; I16 = 0; I26 = 0; D_rs_val = 0;
    E_br_valid = 0; E_PC = 0; E_I16 = 0; E_pred_taken = 0; E_b_jump = 0;
  endtask
  task automatic e_branch(input logic [31:0] pc, input logic [15:0] off, input logic p, input logic j);
    E_br_valid = 1; E_PC = pc; E_I16 = off; E_pred_taken = p; E_b_jump = j;
  endtask
  task automatic test_reset;
    idle_inputs();
    reset = 1;
    tick(); tick();
    reset = 0;
    chk("reset_pc", PC_F, 32'h3000);
    tick(); chk("idle1", PC_F, 32'h3004);
    tick(); chk("idle2", PC_F, 32'h3008);
    tick(); chk("idle3", PC_F, 32'h300C);
  endtask
  task automatic test_cold_branch;
    D_NPC_sel = 2; PC_D = 32'h3010; I16 = 16'h0004;
    #1 chk("cold_pred", {31'd0, D_pred_taken}, 0);
    tick(); chk("cold_pc4", PC_F, 32'h3010);
    idle_inputs();
    e_branch(32'h3010, 16'h0004, 0, 1);
    #1 chk("cold_mispredict", {31'd0, mispredict}, 1);
    chk("cold_flush", {31'd0, flush_F}, 1);
    tick(); chk("cold_redirect", PC_F, 32'h3024);
    idle_inputs();
  endtask
  task automatic test_trained;
    D_NPC_sel = 2; PC_D = 32'h3010; I16 = 16'h0004;
    #1 chk("trained_pred", {31'd0, D_pred_taken}, 1);
    tick(); chk("trained_tgt", PC_F, 32'h3024);
    idle_inputs();
    e_branch(32'h3010, 16'h0004, 1, 1);
    #1 chk("trained_no_mp", {31'd0, mispredict}, 0);
    chk("trained_no_flush", {31'd0, flush_F}, 0);
    tick(); chk("trained_pc4", PC_F, 32'h3028);
    tick(); chk("sat_pc4", PC_F, 32'h302C);
    idle_inputs();
  endtask
  task automatic test_mispredict_stall;
    stall = 1; D_NPC_sel = 2; PC_D = 32'h3010; I16 = 16'h0004;
    e_branch(32'h3010, 16'h0004, 1, 0);
    #1 chk("pre_update_read", {31'd0, D_pred_taken}, 1);
    chk("nt_mispredict", {31'd0, mispredict}, 1);
    tick(); chk("mp_beats_stall", PC_F, 32'h3018);
    idle_inputs();
    PC_D = 32'h3010;
    #1 chk("sel0_no_pred", {31'd0, D_pred_taken}, 0);
    D_NPC_sel = 2;
    #1 chk("sat_then_dec_pred", {31'd0, D_pred_taken}, 1);
    e_branch(32'h3010, 16'h0004, 1, 0);
    tick(); chk("fall_again", PC_F, 32'h3018);
    idle_inputs();
    D_NPC_sel = 2; PC_D = 32'h3010;
    #1 chk("weak_nt_pred", {31'd0, D_pred_taken}, 0);
    idle_inputs();
  endtask
  task automatic test_jumps;
    D_NPC_sel = 1; PC_D = 32'h3000; I26 = 26'h0000C40;
    tick(); chk("jal_tgt", PC_F, 32'h3100);
    D_NPC_sel = 3; D_rs_val = 32'h3FFC;
    tick(); chk("jr_tgt", PC_F, 32'h3FFC);
    stall = 1; D_NPC_sel = 1;
    tick(); chk("stall_j", PC_F, 32'h3FFC);
    D_NPC_sel = 3; D_rs_val = 32'h1234;
    tick(); chk("stall_jr", PC_F, 32'h3FFC);
    idle_inputs();
    D_NPC_sel = 5;
    tick(); chk("sel5_pc4", PC_F, 32'h4000);
    idle_inputs();
    e_branch(32'h3100, 16'hFFFE, 0, 1);
    tick(); chk("neg_offset", PC_F, 32'h30FC);
    idle_inputs();
  endtask
  task automatic test_reset_mid;
    reset = 1;
    e_branch(32'h3010, 16'h0004, 0, 1);
    #1 chk("mp_during_reset", {31'd0, mispredict}, 1);
    tick(); chk("reset_mid_pc", PC_F, 32'h3000);
    idle_inputs();
    tick();
    reset = 0;
    D_NPC_sel = 2; PC_D = 32'h3010;
    #1 chk("bht_reinit", {31'd0, D_pred_taken}, 0);
    idle_inputs();
  endtask
`ifdef NPC_PRED_STATS_EN
  task automatic test_stats;
    logic [1:0] pj [5] = '{2'b00, 2'b11, 2'b01, 2'b10, 2'b00};
    reset = 1;
    tick();
    reset = 0;
    chk("stats_br_reset", br_cnt, 0);
    chk("stats_mp_reset", mispred_cnt, 0);
    for (int i = 0; i < 5; i++) begin
      e_branch(32'h3200, 16'h0000, pj[i][1], pj[i][0]);
      tick();
    end
    idle_inputs();
    tick();
    chk("stats_br", br_cnt, 5);
    chk("stats_mp", mispred_cnt, 2);
    reset = 1;
    tick();
    reset = 0;
    chk("stats_br_clr", br_cnt, 0);
    chk("stats_mp_clr", mispred_cnt, 0);
    chk("stats_pc", PC_F, 32'h3000);
  endtask
`endif
  initial begin
    reset = 1;
    idle_inputs();
    #1;
    test_reset();
    test_cold_branch();
    test_trained();
    test_mispredict_stall();
    test_jumps();
    test_reset_mid();
`ifdef NPC_PRED_STATS_EN
    test_stats();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
